// File: rtl/prl_tx_engine.sv
// prl_tx_engine: transmit engine for a protocol layer.
// Latches a message on TRANSMIT_REQ, checks its byte count, streams header and
// data bytes to the PHY with a valid/ready handshake, waits for a matching
// GoodCRC, and retries up to N_RETRY times before reporting failure.
// Ports:
//   CLK, RESET              clock, asynchronous active-high reset
//   TRANSMIT_*              one-cycle request with latched message contents
//   DISCARD                 abort of the message in flight
//   PHY_TX_*                byte stream to the PHY (VALID/READY, LAST on final byte)
//   GOODCRC_*               received GoodCRC report (MessageID, SOP)
//   TX_BUSY, RETRY_COUNT    status
//   ALERT_*                 one-cycle completion pulses
module prl_tx_engine #(
  parameter int unsigned MAX_DO      = 7,
  parameter int unsigned N_RETRY     = 3,
  parameter int unsigned CRC_TIMEOUT = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          TRANSMIT_REQ,
  input  logic [2:0]                    TRANSMIT_SOP,
  input  logic [7:0]                    TRANSMIT_BYTE_COUNT,
  input  logic [15:0]                   TRANSMIT_HEADER,
  input  logic [32*MAX_DO-1:0]          TRANSMIT_DATA_OBJECTS,
  input  logic                          DISCARD,
  output logic [7:0]                    PHY_TX_DATA,
  output logic                          PHY_TX_VALID,
  output logic                          PHY_TX_LAST,
  input  logic                          PHY_TX_READY,
  input  logic                          GOODCRC_VALID,
  input  logic [2:0]                    GOODCRC_MSGID,
  input  logic [2:0]                    GOODCRC_SOP,
  output logic                          TX_BUSY,
  output logic [$clog2(N_RETRY+2)-1:0]  RETRY_COUNT,
  output logic                          ALERT_SUCCESS,
  output logic                          ALERT_FAILED,
  output logic                          ALERT_DISCARDED
);

  localparam int unsigned RC_W      = $clog2(N_RETRY + 2);
  localparam int unsigned TMR_W     = (CRC_TIMEOUT > 1) ? $clog2(CRC_TIMEOUT) : 1;
  localparam int unsigned DO_W      = 32 * MAX_DO;
  localparam int unsigned MAX_BYTES = 2 + 4 * MAX_DO;

  typedef enum logic [2:0] {
    S_IDLE, S_CONSTRUCT, S_SEND, S_WAIT_CRC, S_CHECK_RETRY, S_REPORT_SUCCESS, S_REPORT_FAIL
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        sop_q, sop_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [15:0]       hdr_q, hdr_d;
  logic [DO_W-1:0]   do_q, do_d;
  logic [RC_W-1:0]   retry_q, retry_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_last_q, tx_last_d;
  logic              busy_q, busy_d;
  logic              al_succ_q, al_succ_d;
  logic              al_fail_q, al_fail_d;
  logic              al_disc_q, al_disc_d;

  // Byte idx of the message: two header bytes, then data bytes little-endian.
  function automatic logic [7:0] pick_byte(input logic [7:0] idx, input logic [15:0] hdr,
                                           input logic [DO_W-1:0] dobj);
    logic [7:0] b;
    b = 8'h00;
    if (idx == 8'd0) begin
      b = hdr[7:0];
    end else if (idx == 8'd1) begin
      b = hdr[15:8];
    end else begin
      for (int unsigned i = 0; i < 4 * MAX_DO; i++) begin
        if ({24'd0, idx} == i + 32'd2) b = dobj[i*8 +: 8];
      end
    end
    return b;
  endfunction

  // Next-state, datapath and registered-output decode.
  always_comb begin
    logic             cnt_ok;
    logic [RC_W-1:0]  retry_inc;
    state_d   = state_q;
    sop_d     = sop_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    do_d      = do_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    al_disc_d = 1'b0;
    cnt_ok    = (cnt_q >= 8'd2) && (cnt_q <= 8'(MAX_BYTES)) && (cnt_q[1:0] == 2'b10);
    retry_inc = (retry_q < RC_W'(N_RETRY + 1)) ? retry_q + RC_W'(1) : retry_q;

    case (state_q)
      S_IDLE: begin
        if (TRANSMIT_REQ && (TRANSMIT_SOP <= 3'd5)) begin
          sop_d   = TRANSMIT_SOP;
          cnt_d   = TRANSMIT_BYTE_COUNT;
          hdr_d   = TRANSMIT_HEADER;
          do_d    = TRANSMIT_DATA_OBJECTS;
          retry_d = '0;
          state_d = S_CONSTRUCT;
        end
      end
      S_CONSTRUCT: begin
        idx_d   = 8'd0;
        state_d = cnt_ok ? S_SEND : S_REPORT_FAIL;
      end
      S_SEND: begin
        if (PHY_TX_READY) begin
          if (idx_q == cnt_q - 8'd1) begin
            timer_d = '0;
            state_d = S_WAIT_CRC;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      S_WAIT_CRC: begin
        // A matching GoodCRC takes priority over the timeout on the same cycle.
        if (GOODCRC_VALID && (GOODCRC_MSGID == hdr_q[11:9]) && (GOODCRC_SOP == sop_q)) begin
          state_d = S_REPORT_SUCCESS;
        end else if (timer_q == TMR_W'(CRC_TIMEOUT - 1)) begin
          state_d = S_CHECK_RETRY;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_CHECK_RETRY: begin
        retry_d = retry_inc;
        if (retry_inc > RC_W'(N_RETRY)) begin
          state_d = S_REPORT_FAIL;
        end else begin
          idx_d   = 8'd0;
          state_d = S_SEND;
        end
      end
      S_REPORT_SUCCESS, S_REPORT_FAIL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any in-flight progress.
    if (DISCARD && (state_q inside {S_CONSTRUCT, S_SEND, S_WAIT_CRC, S_CHECK_RETRY})) begin
      state_d   = S_IDLE;
      idx_d     = 8'd0;
      timer_d   = '0;
      al_disc_d = 1'b1;
    end

    tx_valid_d = (state_d == S_SEND);
    tx_data_d  = tx_valid_d ? pick_byte(idx_d, hdr_q, do_q) : tx_data_q;
    tx_last_d  = tx_valid_d && (idx_d == cnt_q - 8'd1);
    busy_d     = (state_d != S_IDLE);
    al_succ_d  = (state_d == S_REPORT_SUCCESS);
    al_fail_d  = (state_d == S_REPORT_FAIL);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      sop_q      <= 3'd0;
      cnt_q      <= 8'd0;
      hdr_q      <= 16'd0;
      do_q       <= '0;
      retry_q    <= '0;
      timer_q    <= '0;
      idx_q      <= 8'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      al_succ_q  <= 1'b0;
      al_fail_q  <= 1'b0;
      al_disc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sop_q      <= sop_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      do_q       <= do_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      busy_q     <= busy_d;
      al_succ_q  <= al_succ_d;
      al_fail_q  <= al_fail_d;
      al_disc_q  <= al_disc_d;
    end
  end

  assign PHY_TX_DATA     = tx_data_q;
  assign PHY_TX_VALID    = tx_valid_q;
  assign PHY_TX_LAST     = tx_last_q;
  assign TX_BUSY         = busy_q;
  assign RETRY_COUNT     = retry_q;
  assign ALERT_SUCCESS   = al_succ_q;
  assign ALERT_FAILED    = al_fail_q;
  assign ALERT_DISCARDED = al_disc_q;

endmodule

// File: doc/prl_tx_engine.md
PRL_TX_ENGINE -- requirements
Module: prl_tx_engine

Interface
REQ-001 Parameter MAX_DO, default 7: maximum number of 32-bit data objects per message.
REQ-002 Parameter N_RETRY, default 3: retransmissions allowed after the first attempt.
REQ-003 Parameter CRC_TIMEOUT, default 16: cycles to wait for GoodCRC after the last byte is accepted.
REQ-004 Port CLK, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port RESET, input, 1: asynchronous, active-high reset.
REQ-006 Port TRANSMIT_REQ, input, 1: one-cycle transmit request.
REQ-007 Port TRANSMIT_SOP, input, 3: frame type; only 0..5 are valid.
REQ-008 Port TRANSMIT_BYTE_COUNT, input, 8: header bytes plus data bytes.
REQ-009 Port TRANSMIT_HEADER, input, 16: message header; bits [11:9] are the MessageID.
REQ-010 Port TRANSMIT_DATA_OBJECTS, input, 32*MAX_DO: data objects; byte 0 is bits [7:0].
REQ-011 Port DISCARD, input, 1: abort of the current transmission.
REQ-012 Ports PHY_TX_DATA (output, 8), PHY_TX_VALID (output, 1), PHY_TX_LAST (output, 1) and PHY_TX_READY (input, 1): byte stream to the PHY.
REQ-013 Ports GOODCRC_VALID (input, 1), GOODCRC_MSGID (input, 3) and GOODCRC_SOP (input, 3): received GoodCRC report.
REQ-014 Port TX_BUSY, output, 1: high whenever the engine is not in IDLE.
REQ-015 Port RETRY_COUNT, output, $clog2(N_RETRY+2): current retry count.
REQ-016 Ports ALERT_SUCCESS, ALERT_FAILED and ALERT_DISCARDED, output, 1 each: one-cycle pulses.

Function
REQ-017 States: IDLE, CONSTRUCT, SEND, WAIT_CRC, CHECK_RETRY, REPORT_SUCCESS, REPORT_FAIL.
REQ-018 IDLE:
- TRANSMIT_REQ=1 with TRANSMIT_SOP<=5 latches SOP, byte count, header and data objects, clears RETRY_COUNT and goes to CONSTRUCT.
- TRANSMIT_SOP 6 or 7 is ignored.
REQ-019 CONSTRUCT validation:
- Valid byte count: >=2, <=2+4*MAX_DO, and (count-2) a multiple of 4; a valid count goes to SEND with byte index 0.
- Any other count goes to REPORT_FAIL with no byte sent.
REQ-020 SEND byte order: header[7:0], header[15:8], then data bytes 0 to count-3 in ascending order.
REQ-021 SEND handshake:
- PHY_TX_VALID=1 throughout SEND.
- A byte transfers on the cycle VALID=READY=1.
- PHY_TX_DATA holds its value while READY=0.
- PHY_TX_LAST=1 with the final byte.
REQ-022 Latency: a request accepted at cycle 0 gives PHY_TX_VALID=1 and the first byte at cycle 2, with READY held high and zero wait.
REQ-023 Accepting the last byte goes to WAIT_CRC and clears the timer.
REQ-024 WAIT_CRC timer: counts 0..CRC_TIMEOUT-1.
REQ-025 WAIT_CRC decision, made per cycle in this order:
- GOODCRC_VALID=1 with MSGID equal to latched header[11:9] and SOP equal to latched SOP goes to REPORT_SUCCESS.
- A non-matching GoodCRC is ignored.
- Otherwise, timer==CRC_TIMEOUT-1 goes to CHECK_RETRY.
REQ-026 GoodCRC wins if it arrives on the same cycle the timer expires.
REQ-027 CHECK_RETRY: RETRY_COUNT increments, saturating at N_RETRY+1.
- If the new value exceeds N_RETRY, go to REPORT_FAIL.
- Otherwise go to SEND with byte index 0 and the same latched message.
REQ-028 Attempts: N_RETRY+1 in total.
REQ-029 REPORT_SUCCESS and REPORT_FAIL each last one cycle, pulse ALERT_SUCCESS or ALERT_FAILED respectively, then return to IDLE.
REQ-030 DISCARD=1 in any state other than IDLE or REPORT_*:
- Next cycle the state is IDLE and ALERT_DISCARDED pulses.
- PHY_TX_VALID drops that same next cycle.
- A byte handshaken on the DISCARD cycle counts as sent.
REQ-031 TRANSMIT_REQ while TX_BUSY=1 is ignored; no request queuing.
REQ-032 At most one ALERT_* output is high in any cycle.

Reset
REQ-033 RESET=1 forces, asynchronously:
- state IDLE;
- RETRY_COUNT, timer and byte index to 0;
- PHY_TX_VALID, PHY_TX_LAST, TX_BUSY and all ALERT_* to 0;
- PHY_TX_DATA to 8'h00.
REQ-034 Reset during SEND or WAIT_CRC abandons the message with no alert; operation resumes on the first CLK edge after RESET falls.

Verification
REQ-035 Request SOP=0, count=6, header=16'h0A41, DO0=32'h11223344, READY=1, matching GoodCRC 3 cycles after LAST -> bytes 41,0A,44,33,22,11 on cycles 2-7; ALERT_SUCCESS pulse; RETRY_COUNT=0.
REQ-036 No GoodCRC with N_RETRY=3, CRC_TIMEOUT=16 -> message sent 4 times, RETRY_COUNT reaches 4, exactly one ALERT_FAILED, no ALERT_SUCCESS.
REQ-037 Count=5, and separately count=34 with MAX_DO=7 -> ALERT_FAILED at cycle 2; PHY_TX_VALID never asserted.
REQ-038 READY toggled 1,0,0,1 during SEND -> no byte dropped or duplicated; data stable while READY=0; GoodCRC with wrong MSGID ignored; GoodCRC on the timeout cycle -> success.
REQ-039 DISCARD mid-SEND after byte 2 -> VALID low next cycle, ALERT_DISCARDED once, IDLE; a new request is accepted and completes normally.
REQ-040 RESET pulse mid-WAIT_CRC -> all outputs 0 immediately; no alert; next request succeeds with RETRY_COUNT=0.
